// File: rtl/lab5_mem_mem_arbiter.sv
// Round-robin arbiter sharing one blocking memory port among p_num_ports requesters.
// Request registered (memreq one cycle after accept); response routed back combinationally to the granted port.
module lab5_mem_mem_arbiter #(
  parameter int p_num_ports    = 2,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 128,
  localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
  localparam int c_rq_nbits    = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
  localparam int c_rs_nbits    = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits,
  localparam int c_pw          = (p_num_ports > 1) ? $clog2(p_num_ports) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_ports-1:0]            req_val,
  output logic [p_num_ports-1:0]            req_rdy,
  input  logic [p_num_ports*c_rq_nbits-1:0] req_msg,
  output logic [p_num_ports-1:0]            resp_val,
  input  logic [p_num_ports-1:0]            resp_rdy,
  output logic [p_num_ports*c_rs_nbits-1:0] resp_msg,
  output logic                              memreq_val,
  input  logic                              memreq_rdy,
  output logic [c_rq_nbits-1:0]             memreq_msg,
  input  logic                              memresp_val,
  output logic                              memresp_rdy,
  input  logic [c_rs_nbits-1:0]             memresp_msg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                 state;
  logic [c_pw-1:0]        rr_ptr;
  logic [c_pw-1:0]        grant;
  logic [c_rq_nbits-1:0]  req_reg;

  logic [p_num_ports-1:0] rot;
  logic [c_pw-1:0]        off;
  logic [c_pw:0]          w_sum;
  logic [c_pw-1:0]        winner;
  logic                   any_val;

  // Rotate so that bit 0 is the port at rr_ptr; the lowest set bit is the winner's offset.
  always_comb begin
    rot     = (req_val >> rr_ptr) | (req_val << (p_num_ports - int'(rr_ptr)));
    any_val = |req_val;
    off     = '0;
    for (int i = p_num_ports - 1; i >= 0; i--) begin
      if (rot[i]) off = c_pw'(i);
    end
    w_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (w_sum >= (c_pw + 1)'(p_num_ports)) w_sum = w_sum - (c_pw + 1)'(p_num_ports);
    winner = w_sum[c_pw-1:0];
  end

  // req_rdy depends on req_val but never the reverse, so no combinational loop with a source.
  always_comb begin
    req_rdy = '0;
    if (reset && state == ST_IDLE && any_val) req_rdy[winner] = 1'b1;
    resp_val = '0;
    if (state == ST_WAIT) resp_val[grant] = memresp_val;
    memresp_rdy = (state == ST_WAIT) && resp_rdy[grant];
    memreq_val  = (state == ST_SEND);
    memreq_msg  = req_reg;
    resp_msg    = {p_num_ports{memresp_msg}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      req_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_val) begin
            req_reg <= req_msg[winner*c_rq_nbits +: c_rq_nbits];
            grant   <= winner;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (memreq_rdy) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (memresp_val && resp_rdy[grant]) begin
            rr_ptr <= (grant == c_pw'(p_num_ports - 1)) ? '0 : grant + c_pw'(1);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Three-character trace: state letter, grant digit, space.
  function automatic logic [23:0] line_trace();
    logic [7:0] c;
    case (state)
      ST_IDLE: c = "I";
      ST_SEND: c = "S";
      default: c = "W";
    endcase
    return {c, 8'h30 + 8'(grant), 8'h20};
  endfunction

endmodule

// File: tb/tb_lab5_mem_mem_arbiter.sv
// Directed bench for lab5_mem_mem_arbiter with a behavioural memory, sources and sinks.
module tb_lab5_mem_mem_arbiter;
  localparam int N  = 3;
  localparam int RQ = 175;
  localparam int RS = 143;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
  logic [N*RQ-1:0] req_msg;
  logic [N*RS-1:0] resp_msg;
  logic            memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [RQ-1:0]   memreq_msg;
  logic [RS-1:0]   memresp_msg;

  lab5_mem_mem_arbiter #(.p_num_ports(N)) dut (
    .clk(clk), .reset(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [RQ-1:0]  src_q [N][$];
  logic [RS-1:0]  exp_q [N][$];
  logic [RS-1:0]  got_q [N][$];
  logic [RQ-1:0]  acc_q [$];
  logic [1:0]     glog [$];
  logic [127:0]   mem_arr [logic [31:0]];

  int src_cnt [N];
  int sink_cnt [N];
  int mrq_cnt, mrs_cnt;
  int src_max, sink_max, mem_max;
  bit sink_hold, pend, just_acc;
  int viol;
  logic [RS-1:0]  pend_msg;
  logic [1:0]     owner;
  logic [2:0]     m_t;
  logic [7:0]     m_o;
  logic [31:0]    m_a;
  logic [127:0]   m_d;

  function automatic logic [RQ-1:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [127:0] d);
    return {t, o, a, 4'd0, d};
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                            input logic [127:0] d);
    return {t, o, 4'd0, d};
  endfunction

  task automatic issue(input int p, input logic [2:0] t, input logic [7:0] o,
                       input logic [31:0] a, input logic [127:0] d, input logic [127:0] rd);
    src_q[p].push_back(mk_req(t, o, a, d));
    exp_q[p].push_back(mk_resp(t, o, (t == 3'd1) ? 128'd0 : rd));
  endtask

  // Sources, sinks and memory: inputs set at negedge, handshakes evaluated #1 later.
  initial begin
    req_val = '0; req_msg = '0; resp_rdy = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
    pend = 0; just_acc = 0; viol = 0; mrq_cnt = 0; mrs_cnt = 0; owner = '0; pend_msg = '0;
    for (int i = 0; i < N; i++) begin src_cnt[i] = 0; sink_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; acc_q.delete(); mrq_cnt = 0; mrs_cnt = 0;
        for (int i = 0; i < N; i++) begin src_cnt[i] = 0; sink_cnt[i] = 0; end
      end else if (just_acc && !memreq_val) viol++;
      just_acc = 0;
      for (int i = 0; i < N; i++) begin
        req_val[i] = (src_q[i].size() > 0) && (src_cnt[i] == 0);
        req_msg[i*RQ +: RQ] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        resp_rdy[i] = !sink_hold && (sink_cnt[i] == 0);
      end
      memreq_rdy  = rst_n && !pend && (mrq_cnt == 0);
      memresp_val = rst_n && pend && (mrs_cnt == 0);
      memresp_msg = pend ? pend_msg : '0;
      #1;
      if (rst_n) begin
        for (int j = 0; j < N; j++)
          if (resp_val[j] && (!pend || j != int'(owner))) viol++;
        if (pend && memresp_val && !resp_val[owner]) viol++;
        if (pend && (memresp_rdy !== resp_rdy[owner])) viol++;
        if (!pend && memresp_rdy) viol++;
        if (pend && memreq_val) viol++;
        for (int i = 0; i < N; i++) begin
          if (req_val[i] && req_rdy[i]) begin
            acc_q.push_back(src_q[i].pop_front());
            src_cnt[i] = $urandom_range(0, src_max);
            just_acc = 1;
          end else if (src_cnt[i] > 0) src_cnt[i]--;
          if (resp_val[i] && resp_rdy[i]) begin
            got_q[i].push_back(resp_msg[i*RS +: RS]);
            sink_cnt[i] = $urandom_range(0, sink_max);
          end else if (sink_cnt[i] > 0) sink_cnt[i]--;
        end
        if (pend && memresp_val && memresp_rdy) pend = 0;
        else if (pend && mrs_cnt > 0) mrs_cnt--;
        if (memreq_val && memreq_rdy) begin
          if (acc_q.size() == 0 || acc_q[0] !== memreq_msg) viol++;
          if (acc_q.size() > 0) void'(acc_q.pop_front());
          m_t = memreq_msg[174:172]; m_o = memreq_msg[171:164];
          m_a = memreq_msg[163:132]; m_d = memreq_msg[127:0];
          if (m_t == 3'd1) begin
            mem_arr[m_a] = m_d;
            pend_msg = mk_resp(3'd1, m_o, 128'd0);
          end else pend_msg = mk_resp(3'd0, m_o, mem_arr.exists(m_a) ? mem_arr[m_a] : 128'd0);
          glog.push_back(m_o[7:6]);
          owner = m_o[7:6];
          pend = 1;
          mrq_cnt = $urandom_range(0, mem_max);
          mrs_cnt = $urandom_range(0, mem_max);
        end else if (memreq_val && mrq_cnt > 0) mrq_cnt--;
      end
    end
  end

  task automatic clear_all();
    for (int p = 0; p < N; p++) begin src_q[p].delete(); exp_q[p].delete(); got_q[p].delete(); end
    glog.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_max = 0; sink_max = 0; mem_max = 0; sink_hold = 0;
    clear_all();
    @(negedge clk); @(negedge clk); #2;
    clear_all();
    viol = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_max = 0; sink_max = 0; mem_max = 0; sink_hold = 0;
    for (int p = 0; p < N; p++) src_q[p].push_back(mk_req(3'd0, 8'h00, 32'h0, 128'h0));
    @(negedge clk); #2;
    n_cmp++; if (req_val !== 3'b111) begin n_bad++; $display("FAIL reset_req_val_driven got %b expected 111", req_val); end
    n_cmp++; if (req_rdy !== 3'b000) begin n_bad++; $display("FAIL reset_req_rdy got %b expected 000", req_rdy); end
    n_cmp++; if (resp_val !== 3'b000) begin n_bad++; $display("FAIL reset_resp_val got %b expected 000", resp_val); end
    n_cmp++; if (memreq_val !== 1'b0) begin n_bad++; $display("FAIL reset_memreq_val got %b expected 0", memreq_val); end
    n_cmp++; if (memresp_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_memresp_rdy got %b expected 0", memresp_rdy); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    mem_arr[32'h0] = 128'h0a0b0c0d;
    issue(0, 3'd0, 8'h05, 32'h0, 128'h0, 128'h0a0b0c0d);
    for (int c = 0; c < 100; c++) begin if (got_q[0].size() >= 1) break; @(posedge clk); end
    @(posedge clk);
    n_cmp++; if (got_q[0].size() != 1) begin n_bad++; $display("FAIL single_count got %0d expected 1", got_q[0].size()); end
    n_cmp++; if (got_q[0].size() > 0 && got_q[0][0] !== mk_resp(3'd0, 8'h05, 128'h0a0b0c0d)) begin
      n_bad++; $display("FAIL single_resp got %h expected %h", got_q[0][0], mk_resp(3'd0, 8'h05, 128'h0a0b0c0d)); end
    n_cmp++; if (got_q[1].size() != 0) begin n_bad++; $display("FAIL single_port1_quiet got %0d responses expected 0", got_q[1].size()); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL single_protocol got %0d violations expected 0", viol); end
  endtask

  task automatic test_order(input string name, input int nports, input int nreq);
    logic [31:0] a;
    do_reset();
    for (int s = 0; s < nreq; s++)
      for (int p = 0; p < nports; p++) begin
        a = 32'(p * 'h100 + s * 16);
        mem_arr[a] = {4{a}};
        issue(p, 3'd0, {2'(p), 6'(s)}, a, 128'h0, {4{a}});
      end
    for (int c = 0; c < 400; c++) begin if (glog.size() >= nports * nreq && got_q[nports-1].size() >= nreq) break; @(posedge clk); end
    @(posedge clk);
    n_cmp++; if (glog.size() != nports * nreq) begin n_bad++; $display("FAIL %s_grant_count got %0d expected %0d", name, glog.size(), nports * nreq); end
    for (int k = 0; k < glog.size() && k < nports * nreq; k++) begin
      n_cmp++; if (int'(glog[k]) != k % nports) begin n_bad++; $display("FAIL %s_grant_%0d got port %0d expected port %0d", name, k, glog[k], k % nports); end
    end
    for (int p = 0; p < nports; p++) begin
      n_cmp++; if (got_q[p].size() != exp_q[p].size()) begin n_bad++; $display("FAIL %s_count_p%0d got %0d expected %0d", name, p, got_q[p].size(), exp_q[p].size()); end
      for (int k = 0; k < got_q[p].size() && k < exp_q[p].size(); k++) begin
        n_cmp++; if (got_q[p][k] !== exp_q[p][k]) begin n_bad++; $display("FAIL %s_resp_p%0d_%0d got %h expected %h", name, p, k, got_q[p][k], exp_q[p][k]); end
      end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL %s_protocol got %0d violations expected 0", name, viol); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    do_reset();
    mem_max = 3; sink_max = 5;
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 2; p++) begin
        a = 32'(32'h2000 + p * 'h100 + s * 16);
        mem_arr[a] = {a, ~a, a, ~a};
        issue(p, 3'd0, {2'(p), 6'(s)}, a, 128'h0, {a, ~a, a, ~a});
      end
    for (int c = 0; c < 600; c++) begin if (got_q[0].size() >= 4 && got_q[1].size() >= 4) break; @(posedge clk); end
    for (int p = 0; p < 2; p++) begin
      n_cmp++; if (got_q[p].size() != 4) begin n_bad++; $display("FAIL bp_count_p%0d got %0d expected 4", p, got_q[p].size()); end
      for (int k = 0; k < got_q[p].size() && k < exp_q[p].size(); k++) begin
        n_cmp++; if (got_q[p][k] !== exp_q[p][k]) begin n_bad++; $display("FAIL bp_resp_p%0d_%0d got %h expected %h", p, k, got_q[p][k], exp_q[p][k]); end
      end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bp_protocol got %0d violations expected 0", viol); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sink_hold = 1;
    mem_arr[32'h40] = 128'h77;
    src_q[0].push_back(mk_req(3'd0, 8'h01, 32'h40, 128'h0));
    for (int c = 0; c < 50; c++) begin if (pend) break; @(posedge clk); end
    @(posedge clk); #2;
    n_cmp++; if (resp_val !== 3'b001) begin n_bad++; $display("FAIL rmid_held_resp_val got %b expected 001", resp_val); end
    n_cmp++; if (memresp_rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_held_memresp_rdy got %b expected 0", memresp_rdy); end
    rst_n = 1'b0; #1;
    n_cmp++; if (resp_val !== 3'b000) begin n_bad++; $display("FAIL rmid_resp_val got %b expected 000", resp_val); end
    n_cmp++; if (memreq_val !== 1'b0) begin n_bad++; $display("FAIL rmid_memreq_val got %b expected 0", memreq_val); end
    n_cmp++; if (memresp_rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_memresp_rdy got %b expected 0", memresp_rdy); end
    do_reset();
    issue(1, 3'd1, 8'h6a, 32'h1000, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa, 128'h0);
    for (int c = 0; c < 100; c++) begin if (got_q[1].size() >= 1) break; @(posedge clk); end
    @(posedge clk);
    n_cmp++; if (got_q[1].size() != 1 || got_q[1][0] !== mk_resp(3'd1, 8'h6a, 128'h0)) begin
      n_bad++; $display("FAIL rmid_write_resp got %0d responses, first %h expected %h", got_q[1].size(),
                        (got_q[1].size() > 0) ? got_q[1][0] : '0, mk_resp(3'd1, 8'h6a, 128'h0)); end
    n_cmp++; if (mem_arr[32'h1000] !== 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa) begin
      n_bad++; $display("FAIL rmid_mem_data got %h expected deadbeef0123456789abcdef5555aaaa", mem_arr[32'h1000]); end
    n_cmp++; if (got_q[0].size() != 0) begin n_bad++; $display("FAIL rmid_discarded got %0d port0 responses expected 0", got_q[0].size()); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rmid_protocol got %0d violations expected 0", viol); end
  endtask

  task automatic test_random();
    logic [127:0] wd [2][50];
    logic [31:0]  a;
    do_reset();
    src_max = 7; sink_max = 7; mem_max = 7;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 50; k++) begin
        wd[p][k] = {$urandom, $urandom, $urandom, $urandom};
        a = 32'(32'h10000 * (p + 1) + k * 16);
        issue(p, 3'd1, {2'(p), 6'(k)}, a, wd[p][k], 128'h0);
      end
      for (int k = 0; k < 50; k++) begin
        a = 32'(32'h10000 * (p + 1) + k * 16);
        issue(p, 3'd0, {2'(p), 6'(k)}, a, 128'h0, wd[p][k]);
      end
    end
    for (int c = 0; c < 5000; c++) begin if (got_q[0].size() >= 100 && got_q[1].size() >= 100) break; @(posedge clk); end
    for (int p = 0; p < 2; p++) begin
      n_cmp++; if (got_q[p].size() != 100) begin n_bad++; $display("FAIL rand_count_p%0d got %0d expected 100", p, got_q[p].size()); end
      for (int k = 0; k < got_q[p].size() && k < exp_q[p].size(); k++) begin
        n_cmp++; if (got_q[p][k] !== exp_q[p][k]) begin n_bad++; $display("FAIL rand_resp_p%0d_%0d got %h expected %h", p, k, got_q[p][k], exp_q[p][k]); end
      end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rand_protocol got %0d violations expected 0", viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_order("contention", 2, 3);
    test_backpressure();
    test_order("wrap", 3, 2);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
